// File: rtl/shift_pkg.sv
// Shared opcode encoding and default illegal-op result for the shift pipeline.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SHL  = 3'b000,
        OP_SHR  = 3'b001,
        OP_ASHL = 3'b010,
        OP_ASHR = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101
    } shift_op_e;

    localparam logic [7:0] DEFVAL_DEFAULT = 8'h42;

endpackage

// File: rtl/shift_core.sv
// Combinational shift/rotate datapath operating on an already-extended operand.
module shift_core
    import shift_pkg::*;
#(
    parameter int unsigned SHW    = 4,
    parameter int unsigned RW     = 8,
    parameter logic [RW-1:0] DEFVAL = RW'(DEFVAL_DEFAULT)
) (
    input  logic [RW-1:0]  ext,
    input  logic [SHW-1:0] amt,
    input  logic [2:0]     op,
    input  logic           a_signed,
    output logic [RW-1:0]  result,
    output logic           illegal
);

    logic [31:0]     amt_w;
    logic [31:0]     rot;
    logic            big;
    logic            sign;
    logic [2*RW-1:0] dbl;

    always_comb begin
        amt_w   = 32'(amt);
        big     = (amt_w >= RW);
        rot     = amt_w % RW;
        sign    = a_signed & ext[RW-1];
        dbl     = {ext, ext};
        result  = '0;
        illegal = 1'b0;
        case (shift_op_e'(op))
            OP_SHL, OP_ASHL: result = big ? '0 : (ext << amt);
            OP_SHR:          result = big ? '0 : (ext >> amt);
            OP_ASHR: begin
                // Unsigned operands get a logical fill; oversized amounts saturate to the fill value.
                if (big)
                    result = {RW{sign}};
                else if (a_signed)
                    result = $signed(ext) >>> amt;
                else
                    result = ext >> amt;
            end
            OP_ROL:  result = RW'(dbl >> (RW - rot));
            OP_ROR:  result = RW'(dbl >> rot);
            default: begin
                result  = DEFVAL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage shift unit: S1 captures and extends the request, S2 holds the computed result.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int unsigned   WIDTH  = 4,
    parameter int unsigned   SHW    = 4,
    parameter int unsigned   RW     = 8,
    parameter logic [RW-1:0] DEFVAL = RW'(DEFVAL_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic             a_signed,
    input  logic [SHW-1:0]   amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    result,
    output logic             err
);

    logic             s1_valid_q;
    logic [RW-1:0]    s1_ext_q;
    logic [SHW-1:0]   s1_amt_q;
    logic [2:0]       s1_op_q;
    logic             s1_signed_q;

    logic             out_valid_q;
    logic [RW-1:0]    result_q;
    logic             err_q;

    logic [RW-1:0]    ext_d;
    logic [RW-1:0]    result_d;
    logic             illegal_d;
    logic             s2_free;
    logic             accept;

    // S2 can take a new entry when empty or when its current entry leaves this cycle.
    assign s2_free  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready;
    assign ext_d    = a_signed ? RW'($signed(a)) : RW'(a);

    shift_core #(
        .SHW    (SHW),
        .RW     (RW),
        .DEFVAL (DEFVAL)
    ) u_core (
        .ext      (s1_ext_q),
        .amt      (s1_amt_q),
        .op       (s1_op_q),
        .a_signed (s1_signed_q),
        .result   (result_d),
        .illegal  (illegal_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_ext_q    <= '0;
            s1_amt_q    <= '0;
            s1_op_q     <= '0;
            s1_signed_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (accept) begin
                s1_ext_q    <= ext_d;
                s1_amt_q    <= amt;
                s1_op_q     <= op;
                s1_signed_q <= a_signed;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else if (s2_free) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= result_d;
                if (illegal_d)
                    err_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed self-checking bench for shift_unit_pipe at WIDTH=4, SHW=4, RW=8.
module tb_shift_unit_pipe;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned SHW   = 4;
    localparam int unsigned RW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic             a_signed;
    logic [SHW-1:0]   amt;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    result;
    logic             err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_unit_pipe #(
        .WIDTH  (WIDTH),
        .SHW    (SHW),
        .RW     (RW),
        .DEFVAL (8'h42)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .a_signed  (a_signed),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with an empty pipeline and out_ready=1.
    task automatic send_one(input string tag, input logic [2:0] t_op, input logic [3:0] t_a,
                            input logic t_s, input logic [3:0] t_amt,
                            input logic [7:0] exp_res, input logic exp_err);
        in_valid = 1'b1; op = t_op; a = t_a; a_signed = t_s; amt = t_amt;
        #1 chk({tag, " rdy"}, in_ready, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " lat"}, out_valid, 0);
        @(posedge clk); @(negedge clk);
        chk({tag, " vld"}, out_valid, 1);
        chk({tag, " res"}, result, exp_res);
        chk({tag, " err"}, err, exp_err);
        @(posedge clk); @(negedge clk);
        chk({tag, " drain"}, out_valid, 0);
    endtask

    function automatic logic [7:0] stream_exp(input int i);
        logic [3:0] v;
        v = i[3:0];
        return {v, (v[3] ? 4'hF : 4'h0)};
    endfunction

    logic [7:0] burst_exp [3];
    logic [7:0] held;
    logic       stall;
    int         sent, recv, cyc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; a_signed = 1'b0; amt = '0;
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset err", err, 0);
        chk("reset result", result, 0);
        chk("reset in_ready", in_ready, 1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        send_one("shl",      3'b000, 4'hB, 1'b0, 4'd2, 8'h2C, 1'b0);
        send_one("ashr s",   3'b011, 4'hB, 1'b1, 4'd1, 8'hFD, 1'b0);
        send_one("shr s",    3'b001, 4'hB, 1'b1, 4'd1, 8'h7D, 1'b0);
        send_one("ashr u",   3'b011, 4'hB, 1'b0, 4'd1, 8'h05, 1'b0);
        send_one("shr big",  3'b001, 4'h8, 1'b1, 4'hF, 8'h00, 1'b0);
        send_one("ashr big", 3'b011, 4'h8, 1'b1, 4'hF, 8'hFF, 1'b0);
        send_one("rol",      3'b100, 4'hB, 1'b0, 4'd4, 8'hB0, 1'b0);
        send_one("ashl",     3'b010, 4'hB, 1'b0, 4'd2, 8'h2C, 1'b0);
        send_one("ror",      3'b101, 4'hB, 1'b0, 4'd1, 8'h85, 1'b0);
        send_one("rol mod",  3'b100, 4'hB, 1'b1, 4'd9, 8'hF7, 1'b0);
        send_one("shl 7",    3'b000, 4'h1, 1'b0, 4'd7, 8'h80, 1'b0);
        send_one("shl 8",    3'b000, 4'h1, 1'b0, 4'd8, 8'h00, 1'b0);
        send_one("ashr 8 p", 3'b011, 4'h7, 1'b1, 4'd8, 8'h00, 1'b0);
        send_one("ashr 8 n", 3'b011, 4'h8, 1'b1, 4'd8, 8'hFF, 1'b0);

        send_one("illegal6", 3'b110, 4'h3, 1'b1, 4'd5, 8'h42, 1'b1);
        send_one("post ill", 3'b000, 4'hB, 1'b0, 4'd2, 8'h2C, 1'b1);
        send_one("illegal7", 3'b111, 4'h0, 1'b0, 4'd0, 8'h42, 1'b1);

        // Back-to-back burst with out_ready held high: one result per cycle.
        burst_exp[0] = 8'h10; burst_exp[1] = 8'h20; burst_exp[2] = 8'h30;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                chk("burst vld", out_valid, 1);
                chk("burst res", result, burst_exp[i-2]);
            end else begin
                chk("burst idle", out_valid, 0);
            end
            in_valid = (i < 3); op = 3'b100; a = 4'(i + 1); a_signed = 1'b0; amt = 4'd4;
            @(posedge clk); @(negedge clk);
        end
        chk("burst drain", out_valid, 0);

        // Streaming with random back-pressure.
        sent = 0; recv = 0; cyc = 0; stall = 1'b0; held = '0;
        while (recv < 16 && cyc < 400) begin
            if (stall) begin
                chk("stream hold vld", out_valid, 1);
                chk("stream hold res", result, held);
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 16);
            op = 3'b100; a = sent[3:0]; a_signed = 1'b1; amt = 4'd4;
            #1;
            chk("stream rdy", in_ready, !((sent - recv) == 2 && !out_ready));
            if (out_valid && out_ready) begin
                chk("stream res", result, stream_exp(recv));
                recv++;
            end
            stall = out_valid && !out_ready;
            held  = result;
            if (in_valid && in_ready)
                sent++;
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        chk("stream count", recv, 16);
        chk("stream err sticky", err, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b000; a = 4'h3; a_signed = 1'b0; amt = 4'd1;
        @(posedge clk); @(negedge clk);
        a = 4'h5;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("inflight vld", out_valid, 1);
        chk("inflight rdy", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("async rst vld", out_valid, 0);
        chk("async rst rdy", in_ready, 1);
        chk("async rst err", err, 0);
        chk("async rst res", result, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("post rst vld", out_valid, 0);
            chk("post rst rdy", in_ready, 1);
            @(posedge clk); @(negedge clk);
        end
        send_one("after rst", 3'b000, 4'h3, 1'b0, 4'd1, 8'h06, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_unit_pipe.md
SHIFT_UNIT_PIPE -- requirements
Module: shift_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits.
REQ-002 Parameter SHW, default 4: shift-amount width in bits.
REQ-003 Parameter RW, default 8: result width in bits (RW >= WIDTH).
REQ-004 Parameter DEFVAL, default 8'h42 zero-extended to RW: result for an illegal opcode.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  request present.
REQ-008 in_ready  out  1  request accepted when in_valid && in_ready at a clk edge.
REQ-009 op  in  3  shift opcode (REQ-014).
REQ-010 a  in  WIDTH  operand; a_signed  in  1  selects sign extension of a.
REQ-011 amt  in  SHW  shift amount, always treated as unsigned.
REQ-012 out_valid  out  1; out_ready  in  1; result  out  RW; err  out  1 (sticky illegal-op flag).

Function
REQ-013 a SHALL be extended to RW bits: sign-extended when a_signed=1, zero-extended otherwise; this extended value is ext.
REQ-014 op SHALL select: 000 ext<<amt; 001 ext>>amt (logical); 010 ext<<<amt; 011 ext>>>amt; 100 rotate-left by amt mod RW; 101 rotate-right by amt mod RW; 110/111 illegal.
REQ-015 Op 011 SHALL fill with the sign bit of ext only when a_signed=1, and with zeros when a_signed=0.
REQ-016 Op 010 SHALL be identical to op 000.
REQ-017 For ops 000-011, amt >= RW SHALL give 0, except op 011 with a_signed=1, which SHALL give all copies of the sign bit.
REQ-018 An illegal opcode SHALL give result=DEFVAL and set err on the cycle that result is presented; err SHALL stay high until reset.
REQ-019 The pipeline SHALL have two register stages, S1 (decode/extend) and S2 (compute/result); latency from accept to out_valid SHALL be 2 cycles when out_ready=1.
REQ-020 S2 SHALL hold result/out_valid stable while out_valid && !out_ready.
REQ-021 S1 SHALL advance when S2 is empty or S2 is delivering; in_ready SHALL equal !S1_valid || S1_advances.
REQ-022 With out_ready=1 continuously, throughput SHALL be one result per cycle with no bubbles.
REQ-023 Results SHALL leave in acceptance order; no request is dropped or duplicated under any out_ready pattern.
REQ-024 A simultaneous accept into S1 and delivery from S2 in the same cycle SHALL be legal and lossless.
REQ-025 in_ready SHALL depend combinationally only on pipeline state and out_ready, never on in_valid.

Reset
REQ-026 On rst=1, S1_valid, out_valid and err SHALL clear immediately, and result SHALL clear to 0, independent of clk.
REQ-027 On rst=1 mid-operation, in-flight requests SHALL be discarded; after rst falls, in_ready=1 on the first cycle.

Structure
REQ-028 The opcode enumeration (SHL, SHR, ASHL, ASHR, ROL, ROR) and the DEFVAL default SHALL live in shared package shift_pkg.
REQ-029 The combinational compute SHALL be one sub-module, shift_core (ext, amt, op, a_signed -> result, illegal); stage control stays in shift_unit_pipe.

Verification (WIDTH=4, SHW=4, RW=8)
REQ-030 Op 000: a=4'hB, a_signed=0, amt=2 -> result 8'h2C two cycles after accept.
REQ-031 Op 011: a=4'hB, a_signed=1, amt=1 -> 8'hFD; op 001, same inputs -> 8'h7D; op 011, a_signed=0 -> 8'h05.
REQ-032 Op 001: amt=4'hF, a=4'h8, a_signed=1 -> 8'h00; op 011 -> 8'hFF; op 100: a=4'hB, a_signed=0, amt=4 -> 8'hB0.
REQ-033 Op 110: any inputs -> result 8'h42, err=1 and stays 1; a following legal op -> correct result while err remains 1.
REQ-034 Stream of 16 back-to-back requests with out_ready toggling randomly -> all 16 results in order, stable during stalls, in_ready low only while both stages are full and stalled.
REQ-035 Assert rst with two requests in flight -> out_valid=0 immediately, no stale result after release, next request returns correctly.
